// File: rtl/adc_capture_sequencer_pkg.sv
// Shared definitions for the ADC capture sequencer: state encoding and
// default parameter values.
package adc_seq_pkg;

    localparam int CNT_WIDTH_DEF      = 32;
    localparam int NCHIRP_WIDTH_DEF   = 16;
    localparam int TIMEOUT_CYCLES_DEF = 4096;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_INIT       = 3'd1,
        ST_WAIT_READY = 3'd2,
        ST_FIRE       = 3'd3,
        ST_RUN        = 3'd4,
        ST_GAP        = 3'd5,
        ST_DONE       = 3'd6
    } seq_state_e;

endpackage

// File: rtl/adc_capture_sequencer_if.sv
// Host/FMC150-facing signal bundle of the capture sequencer. The slave
// modport is the sequencer; the master modport is the host/FMC150 side.
interface adc_capture_sequencer_if
    import adc_seq_pkg::*;
#(
    parameter int CNT_WIDTH    = CNT_WIDTH_DEF,
    parameter int NCHIRP_WIDTH = NCHIRP_WIDTH_DEF
);

    logic                    start;
    logic                    abort;
    logic [NCHIRP_WIDTH-1:0] cfg_num_chirps;
    logic [CNT_WIDTH-1:0]    cfg_adc_delay;
    logic [CNT_WIDTH-1:0]    cfg_adc_window;
    logic [CNT_WIDTH-1:0]    cfg_prf_period;
    logic                    chirp_ready;
    logic                    chirp_active;
    logic                    chirp_done;
    logic                    chirp_init;
    // Handshake: chirp_enable is a request held high until chirp_active is
    // observed (after synchronisation); it then drops for the rest of the chirp.
    logic                    chirp_enable;
    logic                    adc_enable;
    logic                    busy;
    logic                    seq_done;
    logic [NCHIRP_WIDTH-1:0] chirp_index;
    logic                    timeout_err;
    logic [2:0]              dbg_state;

    modport slave (
        input  start, abort, cfg_num_chirps, cfg_adc_delay, cfg_adc_window,
               cfg_prf_period, chirp_ready, chirp_active, chirp_done,
        output chirp_init, chirp_enable, adc_enable, busy, seq_done,
               chirp_index, timeout_err, dbg_state
    );

    modport master (
        output start, abort, cfg_num_chirps, cfg_adc_delay, cfg_adc_window,
               cfg_prf_period, chirp_ready, chirp_active, chirp_done,
        input  chirp_init, chirp_enable, adc_enable, busy, seq_done,
               chirp_index, timeout_err, dbg_state
    );

endinterface

// File: rtl/adc_capture_sequencer_sync.sv
// Single-bit two-flop synchroniser for the FMC150 chirp status lines.
module bit_sync_2ff (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/adc_capture_sequencer.sv
// Chirp/ADC acquisition sequencer: init pulse, N chirps at a fixed PRF and a
// delayed adc_enable window per chirp. All outputs come straight from flops.
module adc_capture_sequencer
    import adc_seq_pkg::*;
#(
    parameter int CNT_WIDTH      = CNT_WIDTH_DEF,
    parameter int NCHIRP_WIDTH   = NCHIRP_WIDTH_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input logic                    aclk,
    input logic                    aresetn,
    adc_capture_sequencer_if.slave bus
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [2:0] S_IDLE       = ST_IDLE;
    localparam logic [2:0] S_INIT       = ST_INIT;
    localparam logic [2:0] S_WAIT_READY = ST_WAIT_READY;
    localparam logic [2:0] S_FIRE       = ST_FIRE;
    localparam logic [2:0] S_RUN        = ST_RUN;
    localparam logic [2:0] S_GAP        = ST_GAP;
    localparam logic [2:0] S_DONE       = ST_DONE;

    logic chirp_ready_s, chirp_active_s, chirp_done_s;

    bit_sync_2ff u_sync_ready  (.clk_i(aclk), .rst_ni(aresetn), .d_i(bus.chirp_ready),  .q_o(chirp_ready_s));
    bit_sync_2ff u_sync_active (.clk_i(aclk), .rst_ni(aresetn), .d_i(bus.chirp_active), .q_o(chirp_active_s));
    bit_sync_2ff u_sync_done   (.clk_i(aclk), .rst_ni(aresetn), .d_i(bus.chirp_done),   .q_o(chirp_done_s));

    logic [2:0]              state_q, state_d;
    logic [CNT_WIDTH-1:0]    pcnt_q, pcnt_d, pcnt_inc;
    logic [TW-1:0]           tcnt_q, tcnt_d;
    logic [NCHIRP_WIDTH-1:0] idx_q, idx_d, idx_inc, num_q;
    logic [CNT_WIDTH-1:0]    delay_q, window_q, prf_q;
    logic                    done_seen_q, done_seen_d;
    logic                    timeout_err_q, timeout_err_d;
    logic                    init_q, enable_q, adc_q, seq_done_q, busy_q;
    logic                    load_cfg, next_chirp;

    // Window/period bounds are one bit wider so delay+window cannot overflow.
    logic [CNT_WIDTH:0] win_start, win_end, eff_m1;
    logic               win_closed, period_done, last_chirp, tmo_hit, adc_d;

    assign win_start   = {1'b0, delay_q};
    assign win_end     = win_start + {1'b0, (window_q == '0) ? CNT_WIDTH'(1) : window_q};
    assign eff_m1      = ({1'b0, prf_q} > win_end) ? ({1'b0, prf_q} - (CNT_WIDTH+1)'(1)) : win_end;
    assign pcnt_inc    = (pcnt_q == '1) ? pcnt_q : pcnt_q + CNT_WIDTH'(1);
    assign win_closed  = {1'b0, pcnt_q} >= win_end;
    assign period_done = {1'b0, pcnt_q} >= eff_m1;
    assign idx_inc     = idx_q + NCHIRP_WIDTH'(1);
    assign last_chirp  = (num_q != '0) && (idx_inc == num_q);
    assign tmo_hit     = tcnt_q == TW'(TIMEOUT_CYCLES - 1);

    always_comb begin
        state_d       = state_q;
        pcnt_d        = pcnt_q;
        tcnt_d        = tcnt_q;
        idx_d         = idx_q;
        done_seen_d   = done_seen_q;
        timeout_err_d = timeout_err_q;
        load_cfg      = 1'b0;
        next_chirp    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start && !bus.abort) begin
                    load_cfg      = 1'b1;
                    idx_d         = '0;
                    timeout_err_d = 1'b0;
                    state_d       = S_INIT;
                end
            end
            S_INIT: begin
                state_d = S_WAIT_READY;
                tcnt_d  = '0;
            end
            S_WAIT_READY: begin
                if (chirp_ready_s) begin
                    state_d     = S_FIRE;
                    pcnt_d      = '0;
                    tcnt_d      = '0;
                    done_seen_d = 1'b0;
                end else if (tmo_hit) begin
                    timeout_err_d = 1'b1;
                    state_d       = S_IDLE;
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                end
            end
            S_FIRE: begin
                pcnt_d      = pcnt_inc;
                done_seen_d = done_seen_q | chirp_done_s;
                if (chirp_active_s) begin
                    state_d = S_RUN;
                end else if (tmo_hit) begin
                    timeout_err_d = 1'b1;
                    state_d       = S_IDLE;
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                end
            end
            S_RUN: begin
                pcnt_d      = pcnt_inc;
                done_seen_d = done_seen_q | chirp_done_s;
                if (win_closed && (done_seen_q || chirp_done_s)) begin
                    if (period_done) next_chirp = 1'b1;
                    else             state_d    = S_GAP;
                end
            end
            S_GAP: begin
                pcnt_d = pcnt_inc;
                if (period_done) next_chirp = 1'b1;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Re-fire directly when ready is already up so fire spacing is exact.
        if (next_chirp) begin
            idx_d  = idx_inc;
            tcnt_d = '0;
            if (last_chirp) begin
                state_d = S_DONE;
            end else if (chirp_ready_s) begin
                state_d     = S_FIRE;
                pcnt_d      = '0;
                done_seen_d = 1'b0;
            end else begin
                state_d = S_WAIT_READY;
            end
        end

        if (bus.abort) state_d = S_IDLE;
    end

    assign adc_d = ((state_d == S_FIRE) || (state_d == S_RUN)) &&
                   ({1'b0, pcnt_d} >= win_start) && ({1'b0, pcnt_d} < win_end);

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q       <= S_IDLE;
            pcnt_q        <= '0;
            tcnt_q        <= '0;
            idx_q         <= '0;
            num_q         <= '0;
            delay_q       <= '0;
            window_q      <= '0;
            prf_q         <= '0;
            done_seen_q   <= 1'b0;
            timeout_err_q <= 1'b0;
            init_q        <= 1'b0;
            enable_q      <= 1'b0;
            adc_q         <= 1'b0;
            seq_done_q    <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            pcnt_q        <= pcnt_d;
            tcnt_q        <= tcnt_d;
            idx_q         <= idx_d;
            done_seen_q   <= done_seen_d;
            timeout_err_q <= timeout_err_d;
            init_q        <= (state_d == S_INIT);
            enable_q      <= (state_d == S_FIRE);
            adc_q         <= adc_d;
            seq_done_q    <= (state_d == S_DONE);
            busy_q        <= (state_d != S_IDLE);
            if (load_cfg) begin
                num_q    <= bus.cfg_num_chirps;
                delay_q  <= bus.cfg_adc_delay;
                window_q <= bus.cfg_adc_window;
                prf_q    <= bus.cfg_prf_period;
            end
        end
    end

    assign bus.chirp_init   = init_q;
    assign bus.chirp_enable = enable_q;
    assign bus.adc_enable   = adc_q;
    assign bus.seq_done     = seq_done_q;
    assign bus.busy         = busy_q;
    assign bus.chirp_index  = idx_q;
    assign bus.timeout_err  = timeout_err_q;
    assign bus.dbg_state    = state_q;

endmodule

// File: tb/tb_adc_capture_sequencer.sv
// Directed bench for adc_capture_sequencer with a simple FMC150 chirp responder.
module tb_adc_capture_sequencer;
    import adc_seq_pkg::*;

    localparam int CW = 32;
    localparam int NW = 4;
    localparam int TO = 4096;

    // ---------------- clock / reset ----------------
    logic aclk    = 1'b0;
    logic aresetn = 1'b0;
    always #5 aclk = ~aclk;

    adc_capture_sequencer_if #(.CNT_WIDTH(CW), .NCHIRP_WIDTH(NW)) bus ();

    adc_capture_sequencer #(
        .CNT_WIDTH(CW), .NCHIRP_WIDTH(NW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .aclk(aclk), .aresetn(aresetn), .bus(bus)
    );

    // FMC150 model: active 5..19 cycles after the chirp_enable rise, done pulse at 20.
    int   resp_k  = -1;
    logic en_seen = 1'b0;
    always @(negedge aclk) begin
        if (bus.chirp_enable && !en_seen) resp_k = 0;
        else if (resp_k >= 0)             resp_k = resp_k + 1;
        en_seen          = bus.chirp_enable;
        bus.chirp_active = (resp_k >= 5) && (resp_k < 20);
        bus.chirp_done   = (resp_k == 20);
        if (resp_k >= 21) resp_k = -1;
    end

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int fire_t[$];
    int rise_t[$];
    int len_q[$];
    int n_done;
    int n_init;
    int init_first;
    logic [NW-1:0] idx_fire [20];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int qget(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step();
        @(negedge aclk);
        bus.start = 1'b0;
    endtask

    task automatic start_seq(input int n, input int d, input int w, input int p);
        bus.cfg_num_chirps = NW'(n);
        bus.cfg_adc_delay  = CW'(d);
        bus.cfg_adc_window = CW'(w);
        bus.cfg_prf_period = CW'(p);
        bus.start          = 1'b1;
    endtask

    // Follows one sequence until busy drops; optionally pokes start/cfg mid-run.
    task automatic watch(input int budget, input int inject_at, output int used);
        int   len      = 0;
        logic prev_en  = 1'b0;
        logic prev_adc = 1'b0;
        fire_t.delete(); rise_t.delete(); len_q.delete();
        n_done = 0; n_init = 0; init_first = -1; used = 0;
        while (used < budget && !(used > 0 && !bus.busy)) begin
            step();
            used++;
            if (used == inject_at) begin
                bus.start          = 1'b1;
                bus.cfg_num_chirps = NW'(1);
                bus.cfg_adc_window = CW'(5);
                bus.cfg_prf_period = CW'(7);
            end
            if (bus.chirp_init) begin
                n_init++;
                if (init_first < 0) init_first = used;
            end
            if (bus.chirp_enable && !prev_en) fire_t.push_back(used);
            if (bus.adc_enable && !prev_adc) begin
                rise_t.push_back(used);
                len = 0;
            end
            if (bus.adc_enable) len++;
            if (!bus.adc_enable && prev_adc) len_q.push_back(len);
            if (bus.seq_done) n_done++;
            prev_en  = bus.chirp_enable;
            prev_adc = bus.adc_enable;
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int   used;
        int   n;
        int   nf;
        logic prev_en;

        bus.start = 1'b0; bus.abort = 1'b0; bus.chirp_ready = 1'b1;
        bus.cfg_num_chirps = '0; bus.cfg_adc_delay = '0;
        bus.cfg_adc_window = '0; bus.cfg_prf_period = '0;

        repeat (4) step();
        check("rst_init",    bus.chirp_init,   0);
        check("rst_enable",  bus.chirp_enable, 0);
        check("rst_adc",     bus.adc_enable,   0);
        check("rst_busy",    bus.busy,         0);
        check("rst_done",    bus.seq_done,     0);
        check("rst_index",   bus.chirp_index,  0);
        check("rst_timeout", bus.timeout_err,  0);
        check("rst_state",   bus.dbg_state,    ST_IDLE);
        aresetn = 1'b1;
        repeat (4) step();

        // Nominal, with a start pulse and cfg changes injected mid-sequence.
        start_seq(3, 10, 20, 100);
        watch(2000, 50, used);
        check("nom_finished", used < 2000, 1);
        check("nom_init_first", init_first, 1);
        check("nom_init_count", n_init, 1);
        check("nom_fires", fire_t.size(), 3);
        check("nom_fire0", qget(fire_t, 0), 3);
        check("nom_space1", qget(fire_t, 1) - qget(fire_t, 0), 100);
        check("nom_space2", qget(fire_t, 2) - qget(fire_t, 1), 100);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("nom_rise_off%0d", i), qget(rise_t, i) - qget(fire_t, i), 10);
            check($sformatf("nom_len%0d", i), qget(len_q, i), 20);
        end
        check("nom_seq_done", n_done, 1);
        check("nom_index", bus.chirp_index, 3);
        repeat (3) step();

        // Period clamp: max(40, 50+80+1) = 131.
        start_seq(2, 50, 80, 40);
        watch(2000, -1, used);
        check("clamp_fires", fire_t.size(), 2);
        check("clamp_space", qget(fire_t, 1) - qget(fire_t, 0), 131);
        check("clamp_rise_off", qget(rise_t, 0) - qget(fire_t, 0), 50);
        check("clamp_len0", qget(len_q, 0), 80);
        check("clamp_len1", qget(len_q, 1), 80);
        check("clamp_index", bus.chirp_index, 2);
        repeat (3) step();

        // Zero window behaves as one cycle.
        start_seq(1, 3, 0, 10);
        watch(500, -1, used);
        check("w0_rise_off", qget(rise_t, 0) - qget(fire_t, 0), 3);
        check("w0_len", qget(len_q, 0), 1);
        check("w0_seq_done", n_done, 1);
        check("w0_index", bus.chirp_index, 1);
        repeat (3) step();

        // Timeout in WAIT_READY.
        bus.chirp_ready = 1'b0;
        repeat (4) step();
        start_seq(2, 10, 20, 100);
        n = 0; n_done = 0;
        while (!bus.timeout_err && n < 5000) begin
            step();
            n++;
            if (bus.seq_done) n_done++;
        end
        check("to_latency", n, 4098);
        check("to_err", bus.timeout_err, 1);
        check("to_busy", bus.busy, 0);
        check("to_enable", bus.chirp_enable, 0);
        check("to_init", bus.chirp_init, 0);
        check("to_adc", bus.adc_enable, 0);
        check("to_no_done", n_done, 0);
        bus.chirp_ready = 1'b1;
        repeat (4) step();
        check("to_err_sticky", bus.timeout_err, 1);
        start_seq(1, 3, 0, 10);
        watch(500, -1, used);
        check("to_err_cleared", bus.timeout_err, 0);
        check("to_restart_done", n_done, 1);
        repeat (3) step();

        // Abort and start together while idle: abort wins.
        bus.abort = 1'b1;
        bus.start = 1'b1;
        step();
        check("abst_init", bus.chirp_init, 0);
        check("abst_busy", bus.busy, 0);
        bus.abort = 1'b0;
        step();

        // Abort mid-window at pcnt=15.
        start_seq(1, 10, 20, 100);
        n = 0;
        do begin
            step();
            n++;
        end while (!bus.chirp_enable && n < 20);
        check("ab_fire_seen", bus.chirp_enable, 1);
        repeat (15) step();
        check("ab_adc_before", bus.adc_enable, 1);
        bus.abort = 1'b1;
        step();
        check("ab_adc_after", bus.adc_enable, 0);
        check("ab_state", bus.dbg_state, ST_IDLE);
        check("ab_busy", bus.busy, 0);
        bus.abort = 1'b0;
        n_done = 0;
        repeat (30) begin
            step();
            if (bus.seq_done) n_done++;
        end
        check("ab_no_done", n_done, 0);

        // Continuous mode: index wraps 15 -> 0.
        start_seq(0, 2, 3, 40);
        nf = 0; n = 0; prev_en = 1'b0; n_done = 0;
        while (nf < 20 && n < 2000) begin
            step();
            n++;
            if (bus.chirp_enable && !prev_en) begin
                idx_fire[nf] = bus.chirp_index;
                nf++;
            end
            prev_en = bus.chirp_enable;
            if (bus.seq_done) n_done++;
        end
        check("cont_fires", nf, 20);
        check("cont_idx15", idx_fire[15], 15);
        check("cont_idx16", idx_fire[16], 0);
        check("cont_idx19", idx_fire[19], 3);
        check("cont_no_done", n_done, 0);
        check("cont_busy", bus.busy, 1);
        bus.abort = 1'b1;
        step();
        check("cont_abort_busy", bus.busy, 0);
        bus.abort = 1'b0;
        repeat (3) step();

        // Reset mid-window.
        start_seq(2, 10, 20, 100);
        repeat (20) step();
        check("mrst_adc_before", bus.adc_enable, 1);
        aresetn = 1'b0;
        step();
        check("mrst_adc", bus.adc_enable, 0);
        check("mrst_busy", bus.busy, 0);
        check("mrst_index", bus.chirp_index, 0);
        check("mrst_state", bus.dbg_state, ST_IDLE);
        aresetn = 1'b1;
        repeat (3) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
